// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide engine.
// The execute stage drives the master side and the engine drives the slave side.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             w_start_i;
  logic [5:0]       w_funct_6_i;
  logic [WIDTH-1:0] w_rs_x_i;
  logic [WIDTH-1:0] w_rt_x_i;
  logic             w_busy_o;
  logic             w_done_o;
  logic             w_div0_o;
  logic [WIDTH-1:0] w_hi_x_o;
  logic [WIDTH-1:0] w_lo_x_o;

  modport master (
    output w_start_i, w_funct_6_i, w_rs_x_i, w_rt_x_i,
    input  w_busy_o, w_done_o, w_div0_o, w_hi_x_o, w_lo_x_o
  );

  modport slave (
    input  w_start_i, w_funct_6_i, w_rs_x_i, w_rt_x_i,
    output w_busy_o, w_done_o, w_div0_o, w_hi_x_o, w_lo_x_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning HI/LO: MULT/MULTU/DIV/DIVU take
// WIDTH CALC cycles plus one FIX cycle; MTHI/MTLO write directly.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          w_clock,
  input  logic          w_reset_n,
  muldiv_unit_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_mag;
  logic               op_div, neg_res, neg_rem;
  logic [WIDTH-1:0]   hi, lo;
  logic               div0;

  logic             can_issue, is_signed, is_muldiv, accept, mt_write;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [WIDTH:0]   mul_sum, div_rem, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] acc_next, prod;
  logic [WIDTH-1:0] quot, rem;

  assign can_issue = (state == IDLE) || (state == DONE);
  assign is_muldiv = (bus.w_funct_6_i == F_MULT) || (bus.w_funct_6_i == F_MULTU) ||
                     (bus.w_funct_6_i == F_DIV)  || (bus.w_funct_6_i == F_DIVU);
  assign is_signed = (bus.w_funct_6_i == F_MULT) || (bus.w_funct_6_i == F_DIV);
  assign accept    = bus.w_start_i && can_issue && is_muldiv;
  assign mt_write  = bus.w_start_i && can_issue &&
                     ((bus.w_funct_6_i == F_MTHI) || (bus.w_funct_6_i == F_MTLO));

  assign rs_neg   = is_signed && bus.w_rs_x_i[WIDTH-1];
  assign rt_neg   = is_signed && bus.w_rt_x_i[WIDTH-1];
  assign a_mag_in = rs_neg ? -bus.w_rs_x_i : bus.w_rs_x_i;
  assign b_mag_in = rt_neg ? -bus.w_rt_x_i : bus.w_rt_x_i;

  // acc holds {partial product high, multiplier} for mul and
  // {partial remainder, dividend/quotient shift register} for div.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, b_mag};
  assign div_ge   = ~div_diff[WIDTH];

  always_comb begin
    acc_next = acc;
    if (op_div)
      acc_next = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    else
      acc_next = {mul_sum, acc[WIDTH-1:1]};
  end

  assign prod = neg_res ? -acc : acc;
  assign quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge w_clock) begin
    if (!w_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: if (count == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge w_clock) begin
    if (!w_reset_n) begin
      hi      <= '0;
      lo      <= '0;
      div0    <= 1'b0;
      acc     <= '0;
      b_mag   <= '0;
      count   <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      if (mt_write) begin
        if (bus.w_funct_6_i == F_MTHI) hi <= bus.w_rs_x_i;
        else                           lo <= bus.w_rs_x_i;
      end
      if (accept) begin
        op_div  <= bus.w_funct_6_i[1];
        neg_res <= rs_neg ^ rt_neg;
        neg_rem <= rs_neg;
        b_mag   <= b_mag_in;
        acc     <= {{WIDTH{1'b0}}, a_mag_in};
        count   <= CW'(WIDTH);
        div0    <= 1'b0;
      end else if (state == CALC) begin
        acc   <= acc_next;
        count <= count - CW'(1);
      end else if (state == FIX) begin
        // A zero divisor leaves the dividend magnitude as remainder, so the
        // sign-restored remainder equals rs; only the quotient needs forcing.
        if (op_div) begin
          hi   <= rem;
          lo   <= (b_mag == '0) ? '1 : quot;
          div0 <= (b_mag == '0);
        end else begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end
      end
    end
  end

  assign bus.w_busy_o = (state == CALC) || (state == FIX);
  assign bus.w_done_o = (state == DONE);
  assign bus.w_div0_o = div0;
  assign bus.w_hi_x_o = hi;
  assign bus.w_lo_x_o = lo;
endmodule
